// File: rtl/fft_pkg.sv
// Shared constants, bank-state type and address helper for the FFT input unit.
package fft_pkg;

    localparam int FFT_N       = 64;
    localparam int FFT_ADDR_W  = 6;
    localparam int FFT_RADIX_W = 3;
    localparam int FFT_WIDTH   = 17;

    typedef enum logic [1:0] {
        EMPTY,
        FULL,
        DRAIN
    } bank_state_e;

    // Stride-8 transpose: output k reads input 8*(k mod 8) + (k div 8).
    function automatic logic [FFT_ADDR_W-1:0] fft_transpose(
        input logic [FFT_ADDR_W-1:0] a
    );
        return {a[FFT_RADIX_W-1:0], a[FFT_ADDR_W-1:FFT_RADIX_W]};
    endfunction

endpackage

// File: rtl/fft_input_unit_bank.sv
// 64-entry sample store: synchronous write port, combinational read port.
module sample_bank
    import fft_pkg::*;
#(
    parameter int DW = 2 * FFT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [FFT_ADDR_W-1:0] waddr_i,
    input  logic [DW-1:0]         wdata_i,
    input  logic [FFT_ADDR_W-1:0] raddr_i,
    output logic [DW-1:0]         rdata_o
);

    logic [DW-1:0] mem_q [FFT_N];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft_input_unit.sv
// Natural-order to stride-8 transposed reorder buffer ahead of the FFT core.
// Define FFT_IN_PINGPONG_EN for two banks and back-to-back frames.
module fft_input_unit
    import fft_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_first,
    output logic             out_last
);

    localparam int DW = 2 * WIDTH;
    localparam logic [FFT_ADDR_W-1:0] LAST = FFT_ADDR_W'(FFT_N - 1);
`ifdef FFT_IN_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    bank_state_e           bank_q [2];
    bank_state_e           bank_d [2];
    logic [FFT_ADDR_W-1:0] w_cnt_q, w_cnt_d;
    logic [FFT_ADDR_W-1:0] r_cnt_q, r_cnt_d;
    logic                  wsel_q, wsel_d;
    logic                  rsel_q, rsel_d;
    logic                  obank_q, obank_d;
    logic                  out_valid_q, out_valid_d;
    logic [WIDTH-1:0]      out_re_q, out_re_d;
    logic [WIDTH-1:0]      out_im_q, out_im_d;
    logic                  out_first_q, out_first_d;
    logic                  out_last_q, out_last_d;

    logic                  in_fire;
    logic                  out_fire;
    logic                  rd_avail;
    logic                  load;
    bank_state_e           rd_state;
    logic [DW-1:0]         wdata;
    logic [DW-1:0]         rdata;
    logic [DW-1:0]         rdata0;
    logic [FFT_ADDR_W-1:0] raddr;

    assign in_ready = (bank_q[wsel_q] == EMPTY);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign rd_state = bank_q[rsel_q];
    // r_cnt wraps to 0 after the 64th load, so DRAIN with r_cnt 0 means all loaded.
    assign rd_avail = (rd_state == FULL) ||
                      (rd_state == DRAIN && r_cnt_q != '0);
    assign load     = rd_avail && (!out_valid_q || out_ready);
    assign wdata    = {in_re, in_im};
    assign raddr    = fft_transpose(r_cnt_q);

    sample_bank #(.DW(DW)) u_bank0 (
        .clk_i   (clk),
        .we_i    (in_fire && !wsel_q),
        .waddr_i (w_cnt_q),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata0)
    );

`ifdef FFT_IN_PINGPONG_EN
    logic [DW-1:0] rdata1;

    sample_bank #(.DW(DW)) u_bank1 (
        .clk_i   (clk),
        .we_i    (in_fire && wsel_q),
        .waddr_i (w_cnt_q),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata1)
    );

    assign rdata = rsel_q ? rdata1 : rdata0;
`else
    assign rdata = rdata0;
`endif

    always_comb begin
        bank_d      = bank_q;
        w_cnt_d     = w_cnt_q;
        r_cnt_d     = r_cnt_q;
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        obank_d     = obank_q;
        out_valid_d = out_valid_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;

        if (in_fire) begin
            w_cnt_d = w_cnt_q + 6'd1;
            if (w_cnt_q == LAST) begin
                bank_d[wsel_q] = FULL;
                wsel_d         = wsel_q ^ PP;
            end
        end

        if (out_fire) begin
            out_valid_d = 1'b0;
            if (out_last_q) begin
                bank_d[obank_q] = EMPTY;
            end
        end

        // Read select advances on the last load so the next frame follows without a bubble.
        if (load) begin
            bank_d[rsel_q] = DRAIN;
            out_valid_d    = 1'b1;
            out_re_d       = rdata[DW-1:WIDTH];
            out_im_d       = rdata[WIDTH-1:0];
            out_first_d    = (r_cnt_q == '0);
            out_last_d     = (r_cnt_q == LAST);
            obank_d        = rsel_q;
            r_cnt_d        = r_cnt_q + 6'd1;
            if (r_cnt_q == LAST) begin
                rsel_d = rsel_q ^ PP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            w_cnt_q     <= '0;
            r_cnt_q     <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            obank_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            w_cnt_q     <= w_cnt_d;
            r_cnt_q     <= r_cnt_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            obank_q     <= obank_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_fft_input_unit.sv
// Directed bench for fft_input_unit: ordering, latency, backpressure, reset.
// Works with FFT_IN_PINGPONG_EN defined or undefined.
module tb_fft_input_unit;

    localparam int W = 17;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_re;
    logic [W-1:0] in_im;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_re;
    logic [W-1:0] out_im;
    logic         out_first;
    logic         out_last;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int stalls = 0;
    int last_in_cyc = 0;
    int qb = 0;
    int first_in_cyc = 0;

    logic [2*W+1:0] q_dat [$];
    int             q_cyc [$];

    fft_input_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_first (out_first),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output handshake with the cycle it happened in.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            q_dat.push_back({out_re, out_im, out_first, out_last});
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] e);
        n_vec++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int re, input int im);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_re    = re[W-1:0];
        in_im    = im[W-1:0];
        @(negedge clk);
        while (!in_ready && t < 500) begin
            t++;
            @(negedge clk);
        end
        stalls += t;
        if (t >= 500) chk("push_wait", 64'(in_ready), 64'd1);
        last_in_cyc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push_frame(input int base, input bit gaps);
        for (int n = 0; n < 64; n++) begin
            if (gaps && (n % 3) == 2) tick();
            push(base + n, 63 - n);
        end
    endtask

    task automatic wait_out(input int start, input int cnt);
        int t;
        t = 0;
        while (q_dat.size() < start + cnt && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("out_count", 64'(q_dat.size() - start), 64'(cnt));
        tick();
    endtask

    task automatic check_frame(input int s, input int base, input string tag);
        logic [2*W+1:0] e;
        logic [2*W+1:0] o;
        int n;
        for (int k = 0; k < 64; k++) begin
            n = 8 * (k % 8) + k / 8;
            e = {W'(base + n), W'(63 - n), (k == 0), (k == 63)};
            o = (s + k < q_dat.size()) ? q_dat[s + k] : '1;
            chk($sformatf("%s[%0d]", tag, k), 64'(o), 64'(e));
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_re"}, 64'(out_re), 64'd0);
        chk({tag, "_out_im"}, 64'(out_im), 64'd0);
        chk({tag, "_first_last"}, 64'({out_first, out_last}), 64'd0);
    endtask

    initial begin
        logic [2*W+2:0] prev;
        logic [2*W+2:0] cur;
        bit             hold;
        int             t;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs("por");
        tick();

        // Single ramp frame, consumer always ready.
        qb = q_dat.size();
        push_frame(0, 1'b0);
        wait_out(qb, 64);
        check_frame(qb, 0, "ramp");
        if (q_cyc.size() > qb)
            chk("ramp_latency", 64'(q_cyc[qb] - last_in_cyc), 64'd2);

        // Two frames back to back, in_valid held high.
        qb = q_dat.size();
        stalls = 0;
        push_frame(0, 1'b0);
        first_in_cyc = last_in_cyc;
        push_frame(64, 1'b0);
        wait_out(qb, 128);
        check_frame(qb, 0, "b2b_f1");
        check_frame(qb + 64, 64, "b2b_f2");
`ifdef FFT_IN_PINGPONG_EN
        chk("b2b_in_stalls", 64'(stalls), 64'd0);
        if (q_cyc.size() >= qb + 128) begin
            chk("b2b_f1_latency", 64'(q_cyc[qb] - first_in_cyc), 64'd2);
            chk("b2b_no_gap", 64'(q_cyc[qb + 64] - q_cyc[qb + 63]), 64'd1);
            chk("b2b_f2_latency", 64'(q_cyc[qb + 64] - last_in_cyc), 64'd2);
            // Frame 2's last write lands while frame 1 is still handshaking.
            chk("b2b_overlap",
                64'(last_in_cyc >= q_cyc[qb] && last_in_cyc <= q_cyc[qb + 63]),
                64'd1);
        end
`else
        chk("b2b_in_gap", 64'(stalls >= 65), 64'd1);
`endif

        // Backpressure: out_ready pattern 1,0,0 repeating.
        qb = q_dat.size();
        push_frame(0, 1'b0);
        t    = 0;
        hold = 1'b0;
        prev = '0;
        while (q_dat.size() < qb + 64 && t < 1000) begin
            out_ready = ((t % 3) == 0);
            @(negedge clk);
            cur = {out_valid, out_re, out_im, out_first, out_last};
            if (hold) chk("stall_hold", 64'(cur), 64'(prev));
            hold = out_valid && !out_ready;
            prev = cur;
            tick();
            t++;
        end
        out_ready = 1'b1;
        wait_out(qb, 64);
        check_frame(qb, 0, "bp");

        // Input gaps: in_valid low every third cycle.
        qb = q_dat.size();
        push_frame(0, 1'b1);
        wait_out(qb, 64);
        check_frame(qb, 0, "gap");
        if (q_cyc.size() > qb)
            chk("gap_latency", 64'(q_cyc[qb] - last_in_cyc), 64'd2);

        // Reset while a loaded output is stalled.
        out_ready = 1'b0;
        qb = q_dat.size();
        push_frame(100, 1'b0);
        repeat (4) tick();
        chk("stalled_valid", 64'(out_valid), 64'd1);
        chk("stalled_re", 64'(out_re), 64'd100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs("rst_full");
        tick();
        out_ready = 1'b1;
        repeat (80) tick();
        chk("rst_full_quiet", 64'(q_dat.size() - qb), 64'd0);

        // Reset after 30 samples of a frame.
        qb = q_dat.size();
        for (int n = 0; n < 30; n++) push(300 + n, 63 - n);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs("rst_part");
        tick();
        repeat (80) tick();
        chk("rst_part_quiet", 64'(q_dat.size() - qb), 64'd0);
        push_frame(200, 1'b0);
        wait_out(qb, 64);
        check_frame(qb, 200, "post_rst");
        if (q_cyc.size() > qb)
            chk("post_rst_latency", 64'(q_cyc[qb] - last_in_cyc), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
